nand_cell_bist_ctrl: RTL

- Built-in self-test sequencer for a switch-level N-input CMOS NAND cell.
- Drives every input vector exhaustively onto the cell, waits a programmable settle time, samples the cell output and compares it against the ideal NAND value.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits between the testbench/top-level test controller and the gate-level NAND instance it exercises.

---
 rtl/nand_cell_bist_ctrl_if.sv | 25 ++
 rtl/nand_cell_bist_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nand_cell_bist_ctrl_if.sv
// Control/status bundle between a test controller and the NAND cell BIST sequencer.
// The controller issues start/abort and reads back the run status and results.
interface nand_cell_bist_ctrl_if #(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] fail_cnt;
   logic [N_IN-1:0]  first_fail_vec;
   logic             first_fail_valid;

   modport master (
      output start, abort,
      input  busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, abort,
      output busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/nand_cell_bist_ctrl.sv
// Exhaustive BIST sequencer for an N-input NAND cell: walks every input vector, lets it settle,
// then compares the cell output with the ideal NAND value and accumulates the result.
module nand_cell_bist_ctrl #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nand_cell_bist_ctrl_if.slave ctl,
   output logic [N_IN-1:0]      dut_a,
   input  logic                 dut_y
);
   localparam int unsigned      SET_W     = $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

   typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

   state_e           state_q, state_d;
   logic [N_IN-1:0]  vec_q, vec_d;
   logic [N_IN-1:0]  dut_a_q, dut_a_d;
   logic [SET_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
   logic             ff_valid_q, ff_valid_d;
   logic             mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         vec_q      <= '0;
         dut_a_q    <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_cnt_q <= '0;
         ff_vec_q   <= '0;
         ff_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         dut_a_q    <= dut_a_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_cnt_q <= fail_cnt_d;
         ff_vec_q   <= ff_vec_d;
         ff_valid_q <= ff_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      dut_a_d    = dut_a_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      fail_cnt_d = fail_cnt_q;
      ff_vec_d   = ff_vec_q;
      ff_valid_d = ff_valid_q;
      // Case inequality so that an X or Z from a broken cell counts as a failure.
      mismatch   = (dut_y !== ~&vec_q);

      unique case (state_q)
         StIdle: begin
            if (ctl.start && !ctl.abort) begin
               vec_d      = '0;
               dut_a_d    = '0;
               cnt_d      = SETTLE_LD;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               fail_cnt_d = '0;
               ff_valid_d = 1'b0;
               state_d    = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SET_W'(1)) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!ctl.abort) begin
               if (mismatch) begin
                  if (fail_cnt_q != {CNT_W{1'b1}}) begin
                     fail_cnt_d = fail_cnt_q + 1'b1;
                  end
                  if (!ff_valid_q) begin
                     ff_vec_d   = vec_q;
                     ff_valid_d = 1'b1;
                  end
               end
               // The all-ones vector ends the run so the vector counter never wraps.
               if (vec_q != {N_IN{1'b1}}) begin
                  vec_d   = vec_q + N_IN'(1);
                  dut_a_d = vec_q + N_IN'(1);
                  cnt_d   = SETTLE_LD;
                  state_d = StWait;
               end else begin
                  done_d  = 1'b1;
                  pass_d  = (fail_cnt_d == '0);
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            dut_a_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort overrides everything above; partial counts are kept for inspection.
      if (ctl.abort && (state_q != StIdle)) begin
         state_d    = StIdle;
         busy_d     = 1'b0;
         dut_a_d    = '0;
         done_d     = 1'b0;
         pass_d     = 1'b0;
         vec_d      = vec_q;
         cnt_d      = cnt_q;
         fail_cnt_d = fail_cnt_q;
         ff_vec_d   = ff_vec_q;
         ff_valid_d = ff_valid_q;
      end
   end

   assign dut_a                = dut_a_q;
   assign ctl.busy             = busy_q;
   assign ctl.done             = done_q;
   assign ctl.pass             = pass_q;
   assign ctl.fail_cnt         = fail_cnt_q;
   assign ctl.first_fail_vec   = ff_vec_q;
   assign ctl.first_fail_valid = ff_valid_q;
endmodule
